// File: rtl/mode_handover_ctrl_pkg.sv
// Shared types and constants for the measurement-mode handover controller.
// Mode codes, handover states and the blanked pin values live here.
package mode_handover_ctrl_pkg;

    localparam logic [1:0] MODE_FREQ = 2'd1;
    localparam logic [1:0] MODE_DUTY = 2'd2;

    localparam logic [7:0] SEG_SEL_OFF = 8'hFF;
    localparam logic [7:0] SEG_LED_OFF = 8'hFF;

    typedef enum logic {
        RUN   = 1'b0,
        BLANK = 1'b1
    } hs_state_t;

    typedef struct packed {
        logic       oled_rst;
        logic       oled_dcn;
        logic       oled_clk;
        logic       oled_dat;
        logic [7:0] seg_sel;
        logic [7:0] seg_led;
        logic [3:0] led;
        logic [3:0] col;
    } pin_bundle_t;

    function automatic logic [1:0] other_mode(input logic [1:0] m);
        return (m == MODE_DUTY) ? MODE_FREQ : MODE_DUTY;
    endfunction

endpackage

// File: rtl/mode_handover_ctrl_key_debounce.sv
// Two-flop synchronizer, level debouncer and press pulse for an
// active-low key.
module key_debounce
    import mode_handover_ctrl_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic key_stable,
    output logic key_press
);

    logic        sync0;
    logic        sync1;
    logic [19:0] cnt;

    // key_press is registered alongside the stable level falling
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync0      <= 1'b1;
            sync1      <= 1'b1;
            key_stable <= 1'b1;
            key_press  <= 1'b0;
            cnt        <= '0;
        end else begin
            sync0     <= key_n;
            sync1     <= sync0;
            key_press <= 1'b0;
            if (sync1 == key_stable) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYC - 20'd1) begin
                key_stable <= sync1;
                key_press  <= ~sync1;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

// File: rtl/mode_handover_ctrl.sv
// Mode toggle on SW4 with a blanked handover window and restart pulse,
// plus the shared OLED/segment/LED/column pin mux.
module mode_handover_ctrl
    import mode_handover_ctrl_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYC = 20'd1_000_000,
    parameter logic [23:0] BLANK_CYC    = 24'd10_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sw4,
    input  logic       oled_rst_1,
    input  logic       oled_dcn_1,
    input  logic       oled_clk_1,
    input  logic       oled_dat_1,
    input  logic       oled_rst_2,
    input  logic       oled_dcn_2,
    input  logic       oled_clk_2,
    input  logic       oled_dat_2,
    input  logic [7:0] seg_sel_1,
    input  logic [7:0] seg_sel_2,
    input  logic [7:0] seg_led_1,
    input  logic [7:0] seg_led_2,
    input  logic [3:0] led1,
    input  logic [3:0] led2,
    input  logic [3:0] col1,
    input  logic [3:0] col2,
    output logic       oled_rst,
    output logic       oled_dcn,
    output logic       oled_clk,
    output logic       oled_dat,
    output logic [7:0] seg_sel,
    output logic [7:0] seg_led,
    output logic [3:0] led,
    output logic [3:0] col,
    output logic [1:0] choose,
    output logic [1:0] path_restart,
    output logic       busy
);

    hs_state_t   state;
    logic [23:0] blank_cnt;
    logic        key_press;
    pin_bundle_t p1;
    pin_bundle_t p2;
    pin_bundle_t pins;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .key_n     (sw4),
        .key_stable(),
        .key_press (key_press)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= RUN;
            choose       <= MODE_FREQ;
            blank_cnt    <= '0;
            busy         <= 1'b0;
            path_restart <= 2'b00;
        end else begin
            unique case (state)
                RUN: begin
                    if (key_press) begin
                        state        <= BLANK;
                        choose       <= other_mode(choose);
                        blank_cnt    <= '0;
                        busy         <= 1'b1;
                        path_restart <= (choose == MODE_FREQ) ? 2'b10 : 2'b01;
                    end
                end
                BLANK: begin
                    // presses arriving here are dropped, not queued
                    if (blank_cnt == BLANK_CYC - 24'd1) begin
                        state        <= RUN;
                        busy         <= 1'b0;
                        path_restart <= 2'b00;
                    end else begin
                        blank_cnt <= blank_cnt + 24'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign p1 = {oled_rst_1, oled_dcn_1, oled_clk_1, oled_dat_1,
                 seg_sel_1, seg_led_1, led1, col1};
    assign p2 = {oled_rst_2, oled_dcn_2, oled_clk_2, oled_dat_2,
                 seg_sel_2, seg_led_2, led2, col2};

    logic is_blank;
    logic run_duty;
    logic run_freq;

    assign is_blank = (state == BLANK);
    assign run_duty = !is_blank && (choose == MODE_DUTY);
    assign run_freq = !is_blank && (choose != MODE_DUTY);

    always_comb begin
        pins = p1;
        unique case (1'b1)
            is_blank: begin
                pins          = '0;
                pins.seg_sel  = SEG_SEL_OFF;
                pins.seg_led  = SEG_LED_OFF;
                pins.col      = (choose == MODE_DUTY) ? col2 : col1;
            end
            run_duty: pins = p2;
            run_freq: pins = p1;
            default:  pins = p1;
        endcase
    end

    assign {oled_rst, oled_dcn, oled_clk, oled_dat,
            seg_sel, seg_led, led, col} = pins;

endmodule

// File: tb/tb_mode_handover_ctrl.sv
// Randomized bench for mode_handover_ctrl against a window-based
// reference of the key filter and a countdown model of the handover.
module tb_mode_handover_ctrl;

    localparam int DEB = 8;
    localparam int BLK = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       sw4 = 1'b1;
    logic       oled_rst_1, oled_dcn_1, oled_clk_1, oled_dat_1;
    logic       oled_rst_2, oled_dcn_2, oled_clk_2, oled_dat_2;
    logic [7:0] seg_sel_1, seg_sel_2, seg_led_1, seg_led_2;
    logic [3:0] led1, led2, col1, col2;
    logic       oled_rst, oled_dcn, oled_clk, oled_dat;
    logic [7:0] seg_sel, seg_led;
    logic [3:0] led, col;
    logic [1:0] choose, path_restart;
    logic       busy;

    always #5 sys_clk = ~sys_clk;

    mode_handover_ctrl #(
        .DEBOUNCE_CYC(20'd8),
        .BLANK_CYC   (24'd16)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .sw4         (sw4),
        .oled_rst_1  (oled_rst_1),
        .oled_dcn_1  (oled_dcn_1),
        .oled_clk_1  (oled_clk_1),
        .oled_dat_1  (oled_dat_1),
        .oled_rst_2  (oled_rst_2),
        .oled_dcn_2  (oled_dcn_2),
        .oled_clk_2  (oled_clk_2),
        .oled_dat_2  (oled_dat_2),
        .seg_sel_1   (seg_sel_1),
        .seg_sel_2   (seg_sel_2),
        .seg_led_1   (seg_led_1),
        .seg_led_2   (seg_led_2),
        .led1        (led1),
        .led2        (led2),
        .col1        (col1),
        .col2        (col2),
        .oled_rst    (oled_rst),
        .oled_dcn    (oled_dcn),
        .oled_clk    (oled_clk),
        .oled_dat    (oled_dat),
        .seg_sel     (seg_sel),
        .seg_led     (seg_led),
        .led         (led),
        .col         (col),
        .choose      (choose),
        .path_restart(path_restart),
        .busy        (busy)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int toggles = 0;
    int toggle_cyc = 0;
    int busy_seen = 0;
    int fall_cyc = 0;
    logic [1:0] last_choose = 2'd1;

    // reference state: raw key history, accepted level, mode, blank countdown
    logic [15:0] m_hist;
    logic        m_stable;
    logic        m_pend;
    int          m_mode;
    int          m_blank;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)",
                      tag, obs, exp, cyc);
    endtask

    task automatic rand_paths();
        {oled_rst_1, oled_dcn_1, oled_clk_1, oled_dat_1} = 4'($urandom);
        {oled_rst_2, oled_dcn_2, oled_clk_2, oled_dat_2} = 4'($urandom);
        seg_sel_1 = 8'($urandom);
        seg_sel_2 = 8'($urandom);
        seg_led_1 = 8'($urandom);
        seg_led_2 = 8'($urandom);
        led1 = 4'($urandom);
        led2 = 4'($urandom);
        col1 = 4'($urandom);
        col2 = 4'($urandom);
    endtask

    // level accepted once the last DEB synced samples all disagree with it;
    // synced sample at an edge is the raw key from two edges earlier
    task automatic model_step();
        logic all_diff;
        if (sys_rst) begin
            m_hist = '1;
            m_stable = 1'b1;
            m_pend = 1'b0;
            m_mode = 1;
            m_blank = 0;
        end else begin
            if (m_blank > 0) m_blank--;
            else if (m_pend) begin
                m_mode = 3 - m_mode;
                m_blank = BLK;
            end
            m_hist = {m_hist[14:0], sw4};
            all_diff = 1'b1;
            for (int i = 2; i < 2 + DEB; i++)
                if (m_hist[i] == m_stable) all_diff = 1'b0;
            m_pend = 1'b0;
            if (all_diff) begin
                m_stable = ~m_stable;
                m_pend = !m_stable;
            end
        end
    endtask

    task automatic compare_all();
        logic [27:0] p1, p2, exp_pins;
        logic [1:0]  exp_rs;
        logic        exp_busy;
        p1 = {oled_rst_1, oled_dcn_1, oled_clk_1, oled_dat_1,
              seg_sel_1, seg_led_1, led1, col1};
        p2 = {oled_rst_2, oled_dcn_2, oled_clk_2, oled_dat_2,
              seg_sel_2, seg_led_2, led2, col2};
        exp_busy = (m_blank > 0);
        if (exp_busy)
            exp_pins = {4'b0000, 8'hFF, 8'hFF, 4'b0000,
                        (m_mode == 2) ? col2 : col1};
        else
            exp_pins = (m_mode == 2) ? p2 : p1;
        exp_rs = !exp_busy ? 2'b00 : ((m_mode == 2) ? 2'b10 : 2'b01);
        chk("choose", 32'(choose), 32'(m_mode));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("restart", 32'(path_restart), 32'(exp_rs));
        chk("pins", 32'({oled_rst, oled_dcn, oled_clk, oled_dat,
                         seg_sel, seg_led, led, col}), 32'(exp_pins));
        if (choose !== last_choose) begin
            toggles++;
            toggle_cyc = cyc;
        end
        last_choose = choose;
        if (busy === 1'b1) busy_seen++;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        cyc++;
        @(negedge sys_clk);
        compare_all();
        rand_paths();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rand_paths();
        sys_rst = 1'b1;
        run(2);
        chk("rst_choose", 32'(choose), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_restart", 32'(path_restart), 32'd0);
        sys_rst = 1'b0;
        run(5);
        seg_sel_1 = 8'hA5;
        #1;
        chk("seg_sel_p1", 32'(seg_sel), 32'hA5);

        // clean press: latency, blank length, then path 2 on the pins
        toggles = 0;
        busy_seen = 0;
        sw4 = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cyc - fall_cyc == 12) begin
                chk("blank_seg", 32'(seg_sel), 32'hFF);
                chk("blank_oled_rst", 32'(oled_rst), 32'd0);
                chk("blank_restart", 32'(path_restart), 32'b10);
            end
        end
        sw4 = 1'b1;
        run(30);
        chk("press_toggles", toggles, 1);
        chk("press_latency", toggle_cyc - fall_cyc, 2 + DEB + 1);
        chk("press_blank_len", busy_seen, BLK);
        chk("press_choose", 32'(choose), 32'd2);
        #1;
        chk("run_seg_p2", 32'(seg_sel), 32'(seg_sel_2));

        // short bounce pulses never accepted
        toggles = 0;
        busy_seen = 0;
        for (int k = 0; k < 5; k++) begin
            sw4 = 1'b0;
            run(5);
            sw4 = 1'b1;
            run(3);
        end
        run(15);
        chk("bounce_toggles", toggles, 0);
        chk("bounce_busy", busy_seen, 0);

        // second press lands on the last blank cycle and is dropped
        toggles = 0;
        busy_seen = 0;
        sw4 = 1'b0;
        run(8);
        sw4 = 1'b1;
        run(3);
        chk("restart_freq", 32'(path_restart), 32'b01);
        run(5);
        sw4 = 1'b0;
        run(20);
        sw4 = 1'b1;
        run(30);
        chk("blank_press_toggles", toggles, 1);
        chk("blank_press_len", busy_seen, BLK);
        chk("blank_press_choose", 32'(choose), 32'd1);

        // reset in the middle of the blank window
        sw4 = 1'b0;
        run(9);
        sw4 = 1'b1;
        run(2);
        chk("pre_rst_choose", 32'(choose), 32'd2);
        run(7);
        sys_rst = 1'b1;
        run(1);
        chk("mid_rst_choose", 32'(choose), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_restart", 32'(path_restart), 32'd0);
        #1;
        chk("mid_rst_seg", 32'(seg_sel), 32'(seg_sel_1));
        sys_rst = 1'b0;
        run(20);

        // long hold then bouncy release gives exactly one change
        toggles = 0;
        sw4 = 1'b0;
        run(1000);
        for (int k = 0; k < 12; k++) begin
            sw4 = ~sw4;
            run(int'($urandom_range(1, 5)));
        end
        sw4 = 1'b1;
        run(20);
        chk("hold_toggles", toggles, 1);

        // random key activity with occasional resets
        for (int k = 0; k < 300; k++) begin
            sw4 = 1'($urandom_range(0, 1));
            run(int'($urandom_range(1, 20)));
            if ($urandom_range(0, 40) == 0) begin
                sys_rst = 1'b1;
                run(1);
                sys_rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
